bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter IN_W, default 27, is the binary input width; legal range 1..27.
REQ-002 Port clk, input, 1: clock; every register updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port in_valid, input, 1: bin_in is valid this cycle.
REQ-005 Port in_ready, output, 1: the block can accept a conversion this cycle.
REQ-006 Port bin_in, input, IN_W: unsigned binary value to convert.
REQ-007 Port bcd_out, output, 32: packed BCD for 8 digits; digit 7 (most significant) is in [31:28], digit 0 in [3:0]; feeds the 7-seg scanner num_data directly.
REQ-008 Port out_valid, output, 1: one-cycle pulse when bcd_out has just been updated.
REQ-009 Port ovf, output, 1: the last completed conversion exceeded 99,999,999.
REQ-010 Port busy, output, 1: a conversion is in progress.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (in_ready=1, busy=0) and SHIFT (in_ready=0, busy=1).
REQ-012 Accept = in_valid && in_ready at a rising edge; on accept, load bin_in into the shift register, clear a 36-bit (9-digit) BCD accumulator, clear the iteration counter, go to SHIFT.
REQ-013 In SHIFT, each edge performs one double-dabble iteration: add 3 to every accumulator nibble >= 5, then shift {accumulator, binary} left by 1; exactly IN_W iterations.
REQ-014 The iteration counter SHALL be 5 bits, count 0..IN_W-1, and must not wrap during a conversion.
REQ-015 The edge performing iteration IN_W SHALL write bcd_out and ovf, drive out_valid high for the following cycle only, and return to IDLE.
REQ-016 Latency: an accept at edge k yields out_valid high in the cycle after edge k+IN_W; bcd_out is stable from that cycle onward.
REQ-017 Throughput: in_ready is high during the out_valid cycle, so back-to-back accepts give one result per IN_W+1 cycles.
REQ-018 in_valid while busy SHALL be ignored; bin_in is not sampled and no state changes.
REQ-019 bcd_out SHALL hold its last result indefinitely between conversions, and intermediate iterations never appear on it.
REQ-020 ovf=1 iff the 9th accumulator digit is nonzero at completion; ovf updates only at completion.
REQ-021 Every bcd_out nibble SHALL be in the range 0..9.

Reset
REQ-022 While rst=1: state=IDLE, bcd_out=32'h0, out_valid=0, ovf=0, busy=0, in_ready=1, and the counter and accumulator are cleared.
REQ-023 rst asserted mid-conversion SHALL abort it with no out_valid pulse; the first accept is possible on the first edge with rst=0.
REQ-024 rst has priority over accept and completion in the same cycle.

Configuration
REQ-025 Macro BIN2BCD_SAT_EN compiled in: on overflow, bcd_out=32'h99999999 and ovf=1.
REQ-026 Macro BIN2BCD_SAT_EN absent: on overflow, bcd_out = lower 8 digits (value mod 10^8) and ovf=1.
REQ-027 Without overflow, results SHALL be identical in both builds.

Verification (IN_W=27)
REQ-028 Reset, then bin_in=0 accepted at edge k -> out_valid in the cycle after edge k+27, bcd_out=32'h00000000, ovf=0.
REQ-029 bin_in=12345678, then 99999999 back-to-back -> bcd_out=32'h12345678, then 32'h99999999, 28 cycles apart, ovf=0 both.
REQ-030 bin_in=100000000 -> ovf=1; bcd_out=32'h00000000 (no macro) or 32'h99999999 (BIN2BCD_SAT_EN).
REQ-031 bin_in=134217727 -> ovf=1; bcd_out=32'h34217727 (no macro) or 32'h99999999 (BIN2BCD_SAT_EN).
REQ-032 Accept 555, pulse in_valid with 777 at iterations 3 and 20 -> single result 32'h00000555, no second out_valid.
REQ-033 Accept 4321, assert rst at iteration 10 -> no out_valid, bcd_out=0; accept 9 next -> 32'h00000009 after 28 cycles.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//
// Purpose:
//   Sequential binary-to-BCD converter using the double-dabble algorithm.
//   It performs one shift/add-3 iteration per clock and takes IN_W iterations
//   per conversion. Each result is published on an 8-digit packed BCD bus that
//   can feed a 7-segment scanner directly.
//
//   The internal accumulator holds 9 digits (36 bits). A non-zero ninth digit
//   at completion means the input exceeded 99,999,999, which sets ovf.
//
// Configuration:
//   BIN2BCD_SAT_EN  When defined, an overflowing result saturates bcd_out to
//                   32'h99999999. When undefined (the default), bcd_out carries
//                   the lower 8 digits, i.e. the value mod 10^8.
//                   ovf is set on overflow in both builds.
//
// Ports:
//   clk        in   clock; all registers update on its rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   bin_in is valid this cycle
//   in_ready   out  the block can accept a conversion (IDLE state)
//   bin_in     in   [IN_W-1:0] unsigned binary value
//   bcd_out    out  [31:0] packed BCD, digit 7 in [31:28], digit 0 in [3:0]
//   out_valid  out  one-cycle pulse when bcd_out has just been updated
//   ovf        out  the last completed conversion exceeded 99,999,999
//   busy       out  a conversion is in progress (SHIFT state)
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int IN_W = 27
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] bin_in,
    output logic [31:0]     bcd_out,
    output logic            out_valid,
    output logic            ovf,
    output logic            busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter value during the final (IN_W-th) iteration.
    localparam logic [4:0] LAST_CNT = 5'(IN_W - 1);

    state_t          r_state;
    logic [IN_W-1:0] r_bin;
    logic [35:0]     r_acc;
    logic [4:0]      r_cnt;
    logic [31:0]     r_bcd;
    logic            r_out_valid;
    logic            r_ovf;

    logic [35:0]     w_acc_adj;
    logic [35:0]     w_acc_sh;
    logic            w_ovf;
    logic [31:0]     w_result;

    // Add-3 correction on every digit that is 5 or more, so that the
    // following left shift carries correctly into the next digit.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_adj
            assign w_acc_adj[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5)
                                        ? r_acc[gi*4 +: 4] + 4'd3
                                        : r_acc[gi*4 +: 4];
        end
    endgenerate

    // The accumulator shifts left and takes in the binary MSB.
    assign w_acc_sh = {w_acc_adj[34:0], r_bin[IN_W-1]};
    assign w_ovf    = |w_acc_sh[35:32];

`ifdef BIN2BCD_SAT_EN
    assign w_result = w_ovf ? 32'h9999_9999 : w_acc_sh[31:0];
`else
    assign w_result = w_acc_sh[31:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bin       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_bcd       <= 32'h0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin   <= bin_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc <= w_acc_sh;
                    r_bin <= r_bin << 1;
                    if (r_cnt == LAST_CNT) begin
                        // Only the finished value reaches bcd_out.
                        r_bcd       <= w_result;
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == SHIFT);
    assign bcd_out   = r_bcd;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] bin_in;
    logic [31:0] bcd_out;
    logic        out_valid;
    logic        ovf;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_result_cyc = 0;
    int prev_result_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.IN_W(27)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accepts val, optionally pokes in_valid=777 at iterations 3 and 20,
    // then checks the result in the out_valid cycle and returns there.
    task automatic conv(input string tag, input logic [26:0] val,
                        input logic [31:0] exp_bcd, input logic exp_ovf,
                        input bit poke);
        int start;
        int pulses;
        in_valid = 1'b1;
        bin_in   = val;
        tick();
        in_valid = 1'b0;
        start    = cyc;
        check({tag, "_busy"}, 36'(busy), 36'd1);
        check({tag, "_in_ready_low"}, 36'(in_ready), 36'd0);
        pulses = 0;
        for (int i = 1; i <= 26; i++) begin
            if (poke && (i == 3 || i == 20)) begin
                in_valid = 1'b1;
                bin_in   = 27'd777;
            end
            tick();
            in_valid = 1'b0;
            if (out_valid) pulses++;
        end
        check({tag, "_early_pulse"}, 36'(pulses), 36'd0);
        tick();
        prev_result_cyc = last_result_cyc;
        last_result_cyc = cyc;
        check({tag, "_latency"}, 36'(cyc - start), 36'd27);
        check({tag, "_out_valid"}, 36'(out_valid), 36'd1);
        check({tag, "_bcd"}, 36'(bcd_out), 36'(exp_bcd));
        check({tag, "_ovf"}, 36'(ovf), 36'(exp_ovf));
        check({tag, "_ready_back"}, 36'({in_ready, busy}), 36'b10);
    endtask

    initial begin
        int pulses;
        rst      = 1'b1;
        in_valid = 1'b0;
        bin_in   = '0;
        tick();
        tick();
        check("rst_bcd", 36'(bcd_out), 36'h0);
        check("rst_out_valid", 36'(out_valid), 36'd0);
        check("rst_ovf", 36'(ovf), 36'd0);
        check("rst_ready_busy", 36'({in_ready, busy}), 36'b10);

        rst = 1'b0;
        conv("zero", 27'd0, 32'h0000_0000, 1'b0, 1'b0);
        tick();
        check("zero_pulse_one_cycle", 36'(out_valid), 36'd0);

        // Back-to-back: second accept happens in the out_valid cycle.
        conv("b2b_a", 27'd12345678, 32'h1234_5678, 1'b0, 1'b0);
        conv("b2b_b", 27'd99999999, 32'h9999_9999, 1'b0, 1'b0);
        check("b2b_spacing", 36'(last_result_cyc - prev_result_cyc), 36'd28);
        tick();

`ifdef BIN2BCD_SAT_EN
        conv("ovf_1e8", 27'd100000000, 32'h9999_9999, 1'b1, 1'b0);
        tick();
        conv("ovf_max", 27'd134217727, 32'h9999_9999, 1'b1, 1'b0);
`else
        conv("ovf_1e8", 27'd100000000, 32'h0000_0000, 1'b1, 1'b0);
        tick();
        conv("ovf_max", 27'd134217727, 32'h3421_7727, 1'b1, 1'b0);
`endif
        tick();

        // in_valid while busy is ignored; result must hold afterward.
        conv("ignore", 27'd555, 32'h0000_0555, 1'b0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        check("ignore_no_second", 36'(pulses), 36'd0);
        check("ignore_hold_bcd", 36'(bcd_out), 36'h555);

        // Abort mid-conversion with rst.
        in_valid = 1'b1;
        bin_in   = 27'd4321;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        in_valid = 1'b1;          // rst wins over accept
        bin_in = 27'd42;
        tick();
        check("abort_bcd", 36'(bcd_out), 36'h0);
        check("abort_ready_busy", 36'({in_ready, busy}), 36'b10);
        rst = 1'b0;
        in_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        check("abort_no_pulse", 36'(pulses), 36'd0);
        check("abort_bcd_idle", 36'(bcd_out), 36'h0);
        conv("after_abort", 27'd9, 32'h0000_0009, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
